systolic_array_ws: RTL and testbench
====================================

Name: systolic_array_ws

Overview:
- Parametrised weight-stationary systolic MAC array, ROWS x COLS PEs, replacing the fixed square array.
- Adds integrated input skew and output deskew, a weight-load FSM, valid/ready handshakes with global backpressure, and a per-PE disable map for STRAIT self-recovery.
- Sits between the activation buffer and the accumulator or BIST comparator. Upstream supplies unskewed vectors; downstream receives aligned result vectors.

Parameters:
- ROWS, 8, PE rows; equals the dot-product length.
- COLS, 8, PE columns; equals the number of output channels.
- WEIGHT_WIDTH, 8, signed weight width.
- ACTIVATION_WIDTH, 8, signed activation width.
- PSUM_WIDTH, WEIGHT_WIDTH+ACTIVATION_WIDTH+$clog2(ROWS), signed partial-sum width.

Ports:
- clk  in  1  single clock; all flops rising-edge.
- rst  in  1  asynchronous, active-high reset.
- pe_disable  in  ROWS*COLS  bit r*COLS+c disables PE(r,c); must be static outside LOAD.
- w_valid  in  1  weight row valid.
- w_ready  out  1  array accepts a weight row.
- w_data  in  COLS*WEIGHT_WIDTH  one weight row; column c at slice c.
- a_valid  in  1  activation vector valid.
- a_ready  out  1  array accepts an activation vector.
- a_data  in  ROWS*ACTIVATION_WIDTH  activation vector; row r at slice r.
- a_last  in  1  final vector of the batch.
- o_valid  out  1  result vector valid.
- o_ready  in  1  downstream accepts the result vector.
- o_data  out  COLS*PSUM_WIDTH  result vector; column c at slice c.
- o_last  out  1  result corresponds to the a_last vector.
- busy  out  1  state is not LOAD.

Behaviour:
- Reset (async, rst=1):
  - State goes to LOAD, row counter to 0.
  - All weights, skew, PE and deskew registers go to 0; all pipeline valid bits clear.
  - Outputs: w_ready=1, a_ready=0, o_valid=0, o_last=0, o_data=0, busy=0.
  - Reset mid-batch discards in-flight data; no output is produced for it.
- FSM states: LOAD, COMPUTE, DRAIN.
  - LOAD: w_ready=1, a_ready=0. Each w_valid&&w_ready beat writes w_data into weight row wcnt, then wcnt increments. On the beat with wcnt==ROWS-1, go to COMPUTE and reset wcnt to 0.
  - COMPUTE: w_ready=0, a_ready=adv (defined below). Accepting a vector with a_last=1 moves to DRAIN.
  - DRAIN: a_ready=0. Go to LOAD on the advancing cycle where the a_last result transfers (o_valid&&o_ready&&o_last).
- Global advance: adv = !(o_valid && !o_ready).
  - When adv=0, every skew, PE, deskew and valid register holds.
  - In COMPUTE/DRAIN a bubble is inserted when a_valid=0 and adv=1.
- Datapath, per advancing cycle:
  - Row r activation passes through r skew flops.
  - PE(r,c) registers the activation toward column c+1.
  - PE(r,c) registers psum_out = psum_in + a*w(r,c), signed, wrap at PSUM_WIDTH. Row-0 psum_in = 0.
  - Column c output passes through COLS-1-c deskew flops.
- Disabled PE: psum_out = psum_in, and the activation is still forwarded. The product is excluded from the sum.
- Latency: a vector accepted on advancing cycle t appears on o_data at advancing cycle t+L, where L=ROWS+COLS-1.
  - The valid/last shift register has depth L and shares adv.
  - o_data[c] = sum over enabled r of a[r]*w[r][c].
- Throughput: one vector per cycle when o_ready=1 continuously.
- Weights are stable from the end of LOAD until the return to LOAD.
- w_valid during COMPUTE/DRAIN is ignored.
- Simultaneous a_last acceptance and o_valid stall: the state still goes to DRAIN; the a_last vector is accepted only when adv=1.

Decomposition:
- Package strait_array_pkg:
  - state enum {LOAD, COMPUTE, DRAIN}.
  - Function psum_width(WW, AW, ROWS).
  - Localparam for latency L.
- Sub-module ws_pe: one registered weight-stationary PE with disable bypass and a stall enable.
- Top-level generate loops: skew, grid, deskew, FSM and valid pipeline.

Test Plan (ROWS=COLS=4, default widths):
- Load identity weights, stream a=[1,2,3,4], o_ready=1 -> o_valid exactly 7 cycles after acceptance; o_data=[1,2,3,4].
- Load all weights 127, stream a=[-128]*4 -> each column = -65024, no wrap. 10 back-to-back vectors -> 10 consecutive o_valid cycles.
- All weights 1, pe_disable bit 5 (PE(1,1)), a=[1,1,1,1] -> o_data=[4,3,4,4].
- 6 back-to-back vectors, o_ready low for 3 cycles mid-stream -> a_ready=0 during the stall; no result lost or duplicated; order preserved.
- a_last on the 3rd vector -> o_last on the 3rd result; busy drops and w_ready=1 the cycle after that transfer.
- Assert rst 2 cycles after the 2nd vector is accepted -> o_valid=0 immediately; state LOAD; w_ready=1; a_ready=0; reloaded weights yield correct fresh results.

Source files
------------

// File: rtl/strait_array_pkg.sv
// Shared types and sizing helpers for the weight-stationary systolic array
// and its processing elements.
package strait_array_pkg;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    DRAIN
  } state_e;

  function automatic int psum_width(input int ww, input int aw, input int rows);
    return ww + aw + $clog2(rows);
  endfunction

  function automatic int latency(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  localparam int DEFAULT_ROWS    = 8;
  localparam int DEFAULT_COLS    = 8;
  localparam int DEFAULT_LATENCY = latency(DEFAULT_ROWS, DEFAULT_COLS);

endpackage

// File: rtl/ws_pe.sv
// Weight-stationary MAC cell: holds one weight, forwards the activation east
// and adds its product into the partial sum flowing south.
module ws_pe #(
  parameter int WW = 8,
  parameter int AW = 8,
  parameter int PW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          wLoad_i,
  input  logic          peOff_i,
  input  logic [WW-1:0] w_i,
  input  logic [AW-1:0] a_i,
  input  logic [PW-1:0] psum_i,
  output logic [AW-1:0] a_o,
  output logic [PW-1:0] psum_o
);

  logic [WW-1:0]        w_q;
  logic [AW-1:0]        a_q;
  logic [PW-1:0]        psum_q;
  logic [PW-1:0]        psum_d;
  logic signed [PW-1:0] prod;

  // Operands are sign-extended to the sum width first, so the product is exact
  // and the accumulation wraps naturally at PW bits.
  assign prod   = PW'($signed(a_i)) * PW'($signed(w_q));
  assign psum_d = peOff_i ? psum_i : psum_i + prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q <= '0;
    end else if (wLoad_i) begin
      w_q <= w_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      psum_q <= '0;
    end else if (en_i) begin
      a_q    <= a_i;
      psum_q <= psum_d;
    end
  end

  assign a_o    = a_q;
  assign psum_o = psum_q;

endmodule

// File: rtl/systolic_array_ws.sv
// ROWS x COLS weight-stationary systolic MAC array with input skew, output
// deskew, a weight-load FSM and a single global stall shared by every stage.
module systolic_array_ws
  import strait_array_pkg::*;
#(
  parameter int ROWS             = 8,
  parameter int COLS             = 8,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int PSUM_WIDTH       = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, ROWS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ROWS*COLS-1:0]             pe_disable,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [COLS*WEIGHT_WIDTH-1:0]     w_data,
  input  logic                             a_valid,
  output logic                             a_ready,
  input  logic [ROWS*ACTIVATION_WIDTH-1:0] a_data,
  input  logic                             a_last,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic [COLS*PSUM_WIDTH-1:0]       o_data,
  output logic                             o_last,
  output logic                             busy
);

  localparam int WW  = WEIGHT_WIDTH;
  localparam int AW  = ACTIVATION_WIDTH;
  localparam int PW  = PSUM_WIDTH;
  localparam int L   = latency(ROWS, COLS);
  localparam int WCW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e         state_q;
  logic [WCW-1:0] wCnt_q;
  logic [L-1:0]   vld_q;
  logic [L-1:0]   lst_q;
  logic           adv;
  logic           aAccept;
  logic [ROWS-1:0] wLoad;

  logic [AW-1:0] skewOut [ROWS];
  logic [AW-1:0] actE    [ROWS][COLS];
  logic [PW-1:0] psumV   [ROWS][COLS];
  logic [PW-1:0] colOut  [COLS];
  logic [ROWS-1:0] unusedAct;

  assign o_valid = vld_q[L-1];
  assign o_last  = lst_q[L-1];
  assign adv     = !(o_valid && !o_ready);
  assign a_ready = (state_q == COMPUTE) && adv;
  assign w_ready = (state_q == LOAD);
  assign busy    = (state_q != LOAD);
  assign aAccept = a_valid && a_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      wCnt_q  <= '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (w_valid) begin
            if (wCnt_q == WCW'(ROWS - 1)) begin
              wCnt_q  <= '0;
              state_q <= COMPUTE;
            end else begin
              wCnt_q <= wCnt_q + WCW'(1);
            end
          end
        end
        COMPUTE: begin
          if (aAccept && a_last) state_q <= DRAIN;
        end
        DRAIN: begin
          if (o_valid && o_ready && o_last) state_q <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // The valid/last tags travel alongside the data wavefront so the output
  // knows which deskewed column values form a real result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      lst_q <= '0;
    end else if (adv) begin
      vld_q[0] <= aAccept;
      lst_q[0] <= aAccept && a_last;
      for (int i = 1; i < L; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign wLoad[r]     = (state_q == LOAD) && w_valid && (wCnt_q == WCW'(r));
    assign unusedAct[r] = ^actE[r][COLS-1];

    if (r == 0) begin : g_noskew
      assign skewOut[r] = a_data[0 +: AW];
    end else begin : g_skew
      logic [AW-1:0] sk_q [r];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < r; k++) sk_q[k] <= '0;
        end else if (adv) begin
          sk_q[0] <= a_data[r*AW +: AW];
          for (int k = 1; k < r; k++) sk_q[k] <= sk_q[k-1];
        end
      end
      assign skewOut[r] = sk_q[r-1];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [AW-1:0] actIn;
      logic [PW-1:0] psumIn;

      if (c == 0) begin : g_west
        assign actIn = skewOut[r];
      end else begin : g_inner
        assign actIn = actE[r][c-1];
      end

      if (r == 0) begin : g_top
        assign psumIn = '0;
      end else begin : g_below
        assign psumIn = psumV[r-1][c];
      end

      ws_pe #(
        .WW (WW),
        .AW (AW),
        .PW (PW)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .en_i    (adv),
        .wLoad_i (wLoad[r]),
        .peOff_i (pe_disable[r*COLS + c]),
        .w_i     (w_data[c*WW +: WW]),
        .a_i     (actIn),
        .psum_i  (psumIn),
        .a_o     (actE[r][c]),
        .psum_o  (psumV[r][c])
      );
    end
  end

  // Column c finishes c cycles after column 0, so earlier columns wait longer.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_nodelay
      assign colOut[c] = psumV[ROWS-1][c];
    end else begin : g_delay
      logic [PW-1:0] dsk_q [D];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < D; k++) dsk_q[k] <= '0;
        end else if (adv) begin
          dsk_q[0] <= psumV[ROWS-1][c];
          for (int k = 1; k < D; k++) dsk_q[k] <= dsk_q[k-1];
        end
      end
      assign colOut[c] = dsk_q[D-1];
    end
  end

  always_comb begin
    o_data = '0;
    for (int c = 0; c < COLS; c++) o_data[c*PW +: PW] = colOut[c];
  end

endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed bench for a 4x4 systolic_array_ws: a scoreboard queue is filled on
// every accepted vector and drained on every transferred result.
module tb_systolic_array_ws;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int WW   = 8;
  localparam int AW   = 8;
  localparam int PW   = 18;

  typedef struct {
    logic [COLS*PW-1:0] data;
    logic               last;
    int                 cyc;
    logic               latChk;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ROWS*COLS-1:0]  pe_disable;
  logic                  w_valid;
  logic                  w_ready;
  logic [COLS*WW-1:0]    w_data;
  logic                  a_valid;
  logic                  a_ready;
  logic [ROWS*AW-1:0]    a_data;
  logic                  a_last;
  logic                  o_valid;
  logic                  o_ready;
  logic [COLS*PW-1:0]    o_data;
  logic                  o_last;
  logic                  busy;

  logic signed [WW-1:0]  tbW [ROWS][COLS];
  exp_t                  sbQ [$];
  int                    testCount = 0;
  int                    failCount = 0;
  int                    cyc = 0;
  int                    outCount = 0;
  int                    runLen = 0;
  int                    maxRun = 0;
  logic                  latChk = 1'b0;

  systolic_array_ws #(
    .ROWS             (ROWS),
    .COLS             (COLS),
    .WEIGHT_WIDTH     (WW),
    .ACTIVATION_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pe_disable (pe_disable),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_data     (a_data),
    .a_last     (a_last),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_last     (o_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COLS*PW-1:0] model(input logic [ROWS*AW-1:0] a);
    logic [COLS*PW-1:0] res;
    logic signed [PW-1:0] s;
    logic signed [PW-1:0] p;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      s = '0;
      for (int r = 0; r < ROWS; r++) begin
        if (!pe_disable[r*COLS + c]) begin
          p = $signed(a[r*AW +: AW]) * tbW[r][c];
          s = s + p;
        end
      end
      res[c*PW +: PW] = s;
    end
    return res;
  endfunction

  function automatic logic [ROWS*AW-1:0] packA(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Scoreboard: push on acceptance, pop and compare on result transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_valid && a_ready) begin
      e.data   = model(a_data);
      e.last   = a_last;
      e.cyc    = cyc;
      e.latChk = latChk;
      sbQ.push_back(e);
    end
    if (o_valid) runLen++;
    else runLen = 0;
    if (runLen > maxRun) maxRun = runLen;
    if (o_valid && o_ready) begin
      outCount++;
      if (sbQ.size() == 0) begin
        testCount++;
        failCount++;
        $error("[TB] FAIL unexpected_output: observed %0h, expected no result", o_data);
      end else begin
        e = sbQ.pop_front();
        checkOutput("o_data", o_data, e.data);
        checkOutput("o_last", o_last, e.last);
        if (e.latChk) checkOutput("latency", cyc - e.cyc, 7);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWeights();
    for (int r = 0; r < ROWS; r++) begin
      w_valid = 1'b1;
      for (int c = 0; c < COLS; c++) w_data[c*WW +: WW] = tbW[r][c];
      @(negedge clk);
      checkOutput("load_w_ready", w_ready, 1);
      tick();
    end
    w_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [ROWS*AW-1:0] a, input logic last);
    int n;
    n       = 0;
    a_valid = 1'b1;
    a_data  = a;
    a_last  = last;
    @(negedge clk);
    while (!a_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!a_ready) begin
      testCount++;
      failCount++;
      $error("[TB] FAIL accept_timeout: observed a_ready=0, expected 1");
    end
    tick();
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    checkOutput({tag, "_idle"}, busy, 0);
    checkOutput({tag, "_sb_empty"}, sbQ.size(), 0);
  endtask

  initial begin
    int n;
    int savedOut;
    rst        = 1'b1;
    pe_disable = '0;
    w_valid    = 1'b0;
    w_data     = '0;
    a_valid    = 1'b0;
    a_data     = '0;
    a_last     = 1'b0;
    o_ready    = 1'b1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) tbW[r][c] = '0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_w_ready", w_ready, 1);
    checkOutput("rst_a_ready", a_ready, 0);
    checkOutput("rst_o_valid", o_valid, 0);
    checkOutput("rst_o_last", o_last, 0);
    checkOutput("rst_o_data", o_data, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Identity weights, exact latency
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) tbW[r][c] = (r == c) ? 8'sd1 : 8'sd0;
    loadWeights();
    checkOutput("ident_busy", busy, 1);
    checkOutput("ident_w_ready", w_ready, 0);
    latChk = 1'b1;
    applyStimulus(packA(1, 2, 3, 4), 1'b1);
    latChk = 1'b0;
    waitIdle("ident");

    // Extreme operands, 10 back-to-back vectors
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) tbW[r][c] = 8'sd127;
    loadWeights();
    maxRun = 0;
    for (int k = 0; k < 10; k++) applyStimulus(packA(-128, -128, -128, -128), k == 9);
    waitIdle("extreme");
    checkOutput("extreme_run", maxRun, 10);

    // Disabled PE(1,1)
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) tbW[r][c] = 8'sd1;
    pe_disable = 16'h0020;
    loadWeights();
    applyStimulus(packA(1, 1, 1, 1), 1'b1);
    waitIdle("disable");
    pe_disable = '0;

    // Backpressure mid-stream
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) tbW[r][c] = 8'($urandom_range(0, 255));
    loadWeights();
    savedOut = outCount;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          applyStimulus(packA(k, -k, 3 * k, 7 - k), k == 6);
          repeat (2) tick();
        end
      end
      begin
        n = 0;
        while (!o_valid && n < 100) begin
          tick();
          n++;
        end
        o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checkOutput("stall_a_ready", a_ready, 0);
          checkOutput("stall_o_valid", o_valid, 1);
          tick();
        end
        o_ready = 1'b1;
      end
    join
    waitIdle("stall");
    checkOutput("stall_count", outCount - savedOut, 6);

    // a_last on the third vector
    loadWeights();
    applyStimulus(packA(5, 6, 7, 8), 1'b0);
    applyStimulus(packA(-1, -2, -3, -4), 1'b0);
    applyStimulus(packA(100, -100, 50, -50), 1'b1);
    n = 0;
    @(negedge clk);
    while (!(o_valid && o_ready && o_last) && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("last_busy_before", busy, 1);
    tick();
    checkOutput("last_busy_after", busy, 0);
    checkOutput("last_w_ready_after", w_ready, 1);
    waitIdle("last");

    // Reset mid-batch, then reload and recompute
    loadWeights();
    applyStimulus(packA(9, 9, 9, 9), 1'b0);
    applyStimulus(packA(3, 2, 1, 0), 1'b0);
    tick();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_o_valid", o_valid, 0);
    checkOutput("midrst_w_ready", w_ready, 1);
    checkOutput("midrst_a_ready", a_ready, 0);
    checkOutput("midrst_busy", busy, 0);
    sbQ.delete();
    tick();
    tick();
    rst = 1'b0;
    savedOut = outCount;
    repeat (10) tick();
    checkOutput("midrst_no_output", outCount - savedOut, 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) tbW[r][c] = 8'(r * 4 + c - 7);
    loadWeights();
    applyStimulus(packA(2, -3, 4, -5), 1'b1);
    waitIdle("midrst");
    checkOutput("midrst_fresh_count", outCount - savedOut, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
